// File: rtl/fpa_add_seq_pkg.sv
// Shared types and constants for the sequential multi-word adder.
//   state_t : sequencer FSM states
//   OP_ADD / OP_SUB : encodings of the op input
package fpa_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/word_adder.sv
// Combinational W-bit ripple full-adder chain (one slice of the sequencer).
//   a, b      : W-bit addends
//   carry_in  : carry into bit 0
//   sum       : W-bit sum
//   carry_out : carry out of bit W-1
module word_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W:0] c;

  // Ripple the carry bit by bit
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < int'(W); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = c[W];

endmodule

// File: rtl/multi_word_add_sequencer.sv
// Sequential multi-precision adder/subtractor: one W-bit slice processes
// WORDS words LSW-first, with the slice carry registered between words.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (a, b, op, carry_in)
//   out_valid / out_ready : result handshake (sum, carry_out, overflow)
//   op                    : 0 = a+b+carry_in, 1 = a-b
module multi_word_add_sequencer
  import fpa_add_seq_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               carry_in,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] sum,
  output logic               carry_out,
  output logic               overflow
);

  localparam int unsigned   IW       = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [IW-1:0]            idx;
  logic [WORDS-1:0][W-1:0]  a_q;
  logic [WORDS-1:0][W-1:0]  b_q;
  logic [WORDS-1:0][W-1:0]  sum_q;
  logic                     carry_reg;
  logic                     carry_out_q;
  logic                     overflow_q;

  logic                     accept_c;
  logic                     last_c;
  logic [W-1:0]             slice_a_c;
  logic [W-1:0]             slice_b_c;
  logic [W-1:0]             slice_sum_c;
  logic                     slice_carry_c;
  logic                     ovf_c;

  assign accept_c  = (state == IDLE) && in_valid;
  assign last_c    = (idx == LAST_IDX);

  // Operand word select feeding the single slice
  assign slice_a_c = a_q[idx];
  assign slice_b_c = b_q[idx];

  word_adder #(.W(W)) u_word_adder (
    .a         (slice_a_c),
    .b         (slice_b_c),
    .carry_in  (carry_reg),
    .sum       (slice_sum_c),
    .carry_out (slice_carry_c)
  );

  // Signed overflow from the top word; b_q already holds ~b for subtract
  assign ovf_c = (a_q[WORDS-1][W-1] == b_q[WORDS-1][W-1]) &&
                 (slice_sum_c[W-1] != a_q[WORDS-1][W-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_c)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-word result write and carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept_c) begin
      a_q       <= a;
      b_q       <= (op == OP_SUB) ? ~b : b;
      carry_reg <= (op == OP_ADD) ? carry_in : 1'b1;
      idx       <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= slice_sum_c;
      carry_reg  <= slice_carry_c;
      if (last_c) begin
        // Flags get their own registers so they hold until the next result
        carry_out_q <= slice_carry_c;
        overflow_q  <= ovf_c;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Handshake flags are state decodes; in_ready is masked by reset
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_multi_word_add_sequencer.sv
// Scoreboard bench for multi_word_add_sequencer (W=32, WORDS=4).
module tb_multi_word_add_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned WORDS = 4;
  localparam int unsigned TW    = W * WORDS;
  localparam int          LAT   = WORDS + 1;

  typedef struct {
    logic [TW-1:0] sum;
    logic          co;
    logic          ovf;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          carry_in;
  logic          op;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] sum;
  logic          carry_out;
  logic          overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high
  exp_t exp_q[$];
  exp_t cur;
  bit   holding = 1'b0;

  always #5 clk = ~clk;

  multi_word_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk_vec(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide arithmetic and signed range test
  function automatic exp_t model(input logic [TW-1:0] ma, input logic [TW-1:0] mb,
                                 input logic mop, input logic mcin);
    exp_t                 e;
    logic [TW:0]          u;
    logic signed [TW+1:0] sa, sb, s, smax, smin;
    sa   = $signed({ma[TW-1], ma[TW-1], ma});
    sb   = $signed({mb[TW-1], mb[TW-1], mb});
    smax = '0;
    smax[TW-2:0] = '1;
    smin = '1;
    smin[TW-2:0] = '0;
    if (mop == 1'b0) begin
      u = {1'b0, ma} + {1'b0, mb} + {{TW{1'b0}}, mcin};
      s = sa + sb;
      if (mcin) s = s + 1;
      e.co = u[TW];
    end else begin
      u = {1'b0, ma} - {1'b0, mb};
      s = sa - sb;
      e.co = (ma >= mb);
    end
    e.sum = u[TW-1:0];
    e.ovf = (s > smax) || (s < smin);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [TW-1:0] s, input logic co, input logic ovf);
    exp_t e;
    e.sum = s;
    e.co  = co;
    e.ovf = ovf;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [TW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [TW-1:0] pick();
    logic [TW-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = '1;
      2: begin v = '0; v[TW-1] = 1'b1; end
      3: begin v = '1; v[TW-1] = 1'b0; end
      4: v = TW'($urandom_range(0, 15));
      default: v = rnd();
    endcase
    return v;
  endfunction

  // Offer one transaction and push its expected result
  task automatic send_exp(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v,
                          input logic top, input logic tcin, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_int("in_ready_wait", int'(in_ready), 1);
    if (!in_ready) return;
    a        = ta;
    b        = tb_v;
    op       = top;
    carry_in = tcin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.acc = edge_cnt;
    exp_q.push_back(e);
    in_valid = 1'b0;
    a        = rnd();
    b        = rnd();
  endtask

  task automatic send(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v,
                      input logic top, input logic tcin);
    send_exp(ta, tb_v, top, tcin, model(ta, tb_v, top, tcin));
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while (!(exp_q.size() == 0 && !out_valid) && n < max_cyc);
    chk_int("drain", int'(exp_q.size() == 0 && !out_valid), 1);
  endtask

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
    end
  end

  // Monitor: pop on first sight of each result, then require it to hold
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else if (out_valid) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          chk_int("unexpected_output", 1, 0);
          cur.sum = sum;
          cur.co  = carry_out;
          cur.ovf = overflow;
        end else begin
          cur = exp_q.pop_front();
          chk_vec("sum", sum, cur.sum);
          chk_vec("carry_out", TW'(carry_out), TW'(cur.co));
          chk_vec("overflow", TW'(overflow), TW'(cur.ovf));
          chk_int("latency", edge_cnt - cur.acc + 1, LAT);
        end
        holding = 1'b1;
      end else begin
        chk_vec("sum_hold", sum, cur.sum);
        chk_vec("flags_hold", TW'({carry_out, overflow}), TW'({cur.co, cur.ovf}));
      end
      chk_int("in_ready_in_done", int'(in_ready), 0);
      if (out_ready) holding = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t          bp_e;
    logic [TW-1:0] ta, tb_v, v;
    int            n;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = 1'b0;
    carry_in = 1'b0;
    rdy_mode = 2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_in_ready", int'(in_ready), 0);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_vec("rst_sum", sum, '0);
    chk_vec("rst_flags", TW'({carry_out, overflow}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("post_rst_in_ready", int'(in_ready), 1);

    // Directed vectors
    rdy_mode = 0;
    send_exp(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
             mk(128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0));
    send_exp('1, '0, 1'b0, 1'b1, mk('0, 1'b1, 1'b0));
    ta = '1;
    ta[TW-1] = 1'b0;
    v = '0;
    v[TW-1] = 1'b1;
    send_exp(ta, 128'h1, 1'b0, 1'b0, mk(v, 1'b0, 1'b1));
    v = '1;
    v[0] = 1'b0;
    send_exp(128'd5, 128'd7, 1'b1, 1'b1, mk(v, 1'b0, 1'b0));
    wait_drain(200);

    // Backpressure with junk offered on in_valid
    rdy_mode = 1;
    ta   = rnd();
    tb_v = rnd();
    bp_e = model(ta, tb_v, 1'b0, 1'b1);
    send_exp(ta, tb_v, 1'b0, 1'b1, bp_e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk_int("bp_valid_seen", int'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a        = rnd();
      b        = rnd();
      op       = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 10);
    chk_int("bp_handshake", int'(out_valid && out_ready), 1);
    @(negedge clk);
    chk_int("bp_in_ready_after", int'(in_ready), 1);
    chk_int("bp_valid_dropped", int'(out_valid), 0);
    chk_vec("bp_sum_after_hs", sum, bp_e.sum);
    rdy_mode = 0;
    send(rnd(), rnd(), 1'b1, 1'b0);
    send(rnd(), rnd(), 1'b0, 1'b1);
    wait_drain(200);

    // Reset during the second RUN cycle
    send(rnd(), rnd(), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_int("mid_rst_in_ready", int'(in_ready), 0);
    chk_vec("mid_rst_sum", sum, '0);
    chk_vec("mid_rst_flags", TW'({carry_out, overflow}), '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("mid_rst_in_ready_after", int'(in_ready), 1);
    send_exp(128'd3, 128'd4, 1'b0, 1'b0, mk(128'd7, 1'b0, 1'b0));
    wait_drain(200);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
